uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
//  APB-UART receive path, the counterpart of the transmit stage. It oversamples RXD at 16x,
//  driven by the shared baud 'enable' tick.
//  Deframes start/data/parity/stop per LCR and pushes each received character, plus its error
//  flags, into the external RX FIFO (uart_fifo).
// PARAMETERS
//  SYNC_STAGES  2  RXD synchroniser depth (>=2)
//  MID_SAMPLE   7  tick index (0..15) at which the start bit is re-checked
// PORTS
//  PCLK           in   1  system clock, all logic on rising edge
//  PRESETn        in   1  asynchronous active-low reset
//  RXD            in   1  serial input, asynchronous to PCLK, idle high
//  enable         in   1  16x baud tick, one PCLK wide
//  LCR            in   8  [1:0] word length 5..8, [3] parity enable, [5:3] parity mode
//  rx_fifo_full   in   1  RX FIFO full
//  rx_data        out  8  received character, right-justified, unused MSBs = 0
//  rx_push        out  1  one-cycle push strobe to RX FIFO
//  parity_error   out  1  valid with rx_push
//  framing_error  out  1  valid with rx_push
//  break_int      out  1  valid with rx_push
//  overrun_error  out  1  one-cycle pulse; character dropped because FIFO was full
//  rx_busy        out  1  high from start-bit detection until return to IDLE
// BEHAVIOUR
//  - Reset (async, any time incl. mid-frame): state=IDLE, counters=0, sync flops=1,
//    all outputs 0. No partial character is pushed.
//  - All state, counters and sampling advance only on cycles with enable=1.
//  - rxd_s = RXD after SYNC_STAGES flops. Sampled "bit" = rxd_s on that enable cycle.
//  - Word length N = 5 + LCR[1:0].
//  - States:
//    IDLE: rxd_s==0 on enable -> START, tick=0, rx_busy=1.
//    START: tick++. At tick==MID_SAMPLE: if rxd_s==1 -> false start, back to IDLE, rx_busy=0.
//      Otherwise tick=0, bit_idx=0 -> DATA. This mid-bit alignment holds for the whole frame.
//    DATA: tick++. At tick==15: shift rxd_s into bit[bit_idx] (LSB first), tick=0, bit_idx++.
//      After bit N-1: -> PARITY if LCR[3], else -> STOP.
//    PARITY: at tick==15, sample p. exp = ^data (LCR[5:3]=001), ~^data (011), 1 (101),
//      0 (111). data = the N received bits, zero-extended. parity_error = (p != exp).
//    STOP: at tick==15, sample the first stop bit only (LCR[2] is ignored on receive).
//      framing_error = (bit==0).
//      break_int = data==0, parity bit==0 (if enabled), and stop==0.
//      Result completes. Next state: BRK_WAIT if break_int, else IDLE.
//    BRK_WAIT: stay until rxd_s==1 on an enable cycle, then IDLE.
//      No start detection while in BRK_WAIT.
//  - Completion: in the PCLK cycle after the STOP-sampling enable, rx_push=1 for exactly
//    one cycle. rx_data and the error flags are registered and valid in that cycle;
//    the flags are 0 otherwise.
//  - If rx_fifo_full==1 in the completion cycle: rx_push stays 0, overrun_error pulses 1 cycle.
//  - Framing error without break: return to IDLE. If rxd_s is still 0, a new START is detected
//    on the next enable.
//  - LCR changes mid-frame are not supported; behaviour is undefined until the next IDLE.
// TESTING
//  1. 8N1 (LCR=03h), frame 0xA5 -> exactly one rx_push, rx_data=A5h, all error flags 0.
//  2. 7-bit even (LCR=0Ah), 0x35 with a wrong parity bit -> rx_data=35h, parity_error=1.
//  3. 5-bit no parity (LCR=00h), 0x1F then a 0 stop bit -> rx_data=1Fh, framing_error=1,
//     break_int=0.
//  4. RXD held low for 2 frame times, 8N1 -> rx_data=00h, framing_error=1, break_int=1.
//     No further push until RXD goes high and a new start arrives.
//  5. RXD low for 4 ticks only -> no rx_push, rx_busy drops; then 0x3C is received cleanly.
//  6. rx_fifo_full=1 at completion -> rx_push=0, overrun_error=1 for one cycle.
//     Also: PRESETn pulsed mid-DATA -> outputs 0 at once, no push, next frame received correctly.

Source files
------------

// File: rtl/uart_receiver.sv
// uart_receiver: APB-UART receive path. RXD is synchronised, oversampled at 16x
// on the shared baud 'enable' tick, deframed according to LCR, and each
// completed character is offered to the external RX FIFO with its error flags.
//
// Handshake: rx_push is a one-cycle write strobe into the FIFO. It is raised
// only when rx_fifo_full is low in the completion cycle; otherwise the
// character is dropped and overrun_error pulses in that same cycle instead.
// rx_data and the error flags belong to the cycle in which rx_push is high.
module uart_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int MID_SAMPLE  = 7
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       RXD,
  input  logic       enable,
  input  logic [7:0] LCR,
  input  logic       rx_fifo_full,
  output logic [7:0] rx_data,
  output logic       rx_push,
  output logic       parity_error,
  output logic       framing_error,
  output logic       break_int,
  output logic       overrun_error,
  output logic       rx_busy,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    PARITY   = 3'd3,
    STOP     = 3'd4,
    BRK_WAIT = 3'd5
  } rx_state_t;

  localparam logic [3:0] MID_TICK  = 4'(MID_SAMPLE);
  localparam logic [3:0] LAST_TICK = 4'd15;

  rx_state_t              state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_s;
  logic [3:0]             tick_q, tick_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             data_q, data_d;
  logic                   par_q, par_d;
  logic                   done_q, done_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   pe_q, pe_d;
  logic                   fe_q, fe_d;
  logic                   brk_q, brk_d;
  logic [2:0]             last_idx;
  logic                   exp_par;

  // Index of the final data bit: word length minus one (4..7).
  assign last_idx = {1'b0, LCR[1:0]} + 3'd4;

  // Expected parity bit from the mode field; data_q is zero above the word.
  always_comb begin
    exp_par = 1'b0;
    case (LCR[5:4])
      2'b00:   exp_par = ^data_q;
      2'b01:   exp_par = ~^data_q;
      2'b10:   exp_par = 1'b1;
      default: exp_par = 1'b0;
    endcase
  end

  // Bring the asynchronous RXD into the PCLK domain; idles high.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) sync_q <= '1;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], RXD};
  end

  assign rxd_s = sync_q[SYNC_STAGES-1];

  // State, counters and result registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      par_q     <= 1'b0;
      done_q    <= 1'b0;
      rx_data_q <= '0;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      par_q     <= par_d;
      done_q    <= done_d;
      rx_data_q <= rx_data_d;
      pe_q      <= pe_d;
      fe_q      <= fe_d;
      brk_q     <= brk_d;
    end
  end

  // Next-state logic; everything except the completion strobe holds
  // between enable ticks.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    par_d     = par_q;
    done_d    = 1'b0;
    rx_data_d = rx_data_q;
    pe_d      = pe_q;
    fe_d      = fe_q;
    brk_d     = brk_q;
    if (enable) begin
      case (state_q)
        IDLE: begin
          if (!rxd_s) begin
            state_d = START;
            tick_d  = '0;
            data_d  = '0;
            par_d   = 1'b0;
          end
        end
        START: begin
          // Re-check the start bit near its centre; every later sample is
          // taken 16 ticks after the previous one, so it stays mid-bit.
          if (tick_q == MID_TICK) begin
            tick_d    = '0;
            bit_idx_d = '0;
            state_d   = rxd_s ? IDLE : DATA;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
        DATA: begin
          if (tick_q == LAST_TICK) begin
            tick_d            = '0;
            data_d[bit_idx_q] = rxd_s;
            bit_idx_d         = bit_idx_q + 3'd1;
            if (bit_idx_q == last_idx) state_d = LCR[3] ? PARITY : STOP;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
        PARITY: begin
          if (tick_q == LAST_TICK) begin
            tick_d  = '0;
            par_d   = rxd_s;
            state_d = STOP;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
        STOP: begin
          if (tick_q == LAST_TICK) begin
            tick_d    = '0;
            done_d    = 1'b1;
            rx_data_d = data_q;
            pe_d      = LCR[3] & (par_q != exp_par);
            fe_d      = ~rxd_s;
            brk_d     = (data_q == 8'h00) & ~(LCR[3] & par_q) & ~rxd_s;
            state_d   = brk_d ? BRK_WAIT : IDLE;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
        BRK_WAIT: begin
          if (rxd_s) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Completion outputs: push or overrun depending on FIFO space.
  always_comb begin
    rx_push       = done_q & ~rx_fifo_full;
    overrun_error = done_q & rx_fifo_full;
    parity_error  = pe_q & rx_push;
    framing_error = fe_q & rx_push;
    break_int     = brk_q & rx_push;
    rx_data       = rx_data_q;
    rx_busy       = (state_q != IDLE);
    state_dbg     = state_q;
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed scenarios for the UART receive path.
module tb_uart_receiver;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic       RXD = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] LCR = 8'h03;
  logic       rx_fifo_full = 1'b0;
  logic [7:0] rx_data;
  logic       rx_push;
  logic       parity_error;
  logic       framing_error;
  logic       break_int;
  logic       overrun_error;
  logic       rx_busy;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor state, cumulative; tests work with differences.
  int         push_cnt = 0;
  int         ovr_cnt  = 0;
  int         busy_cnt = 0;
  logic [7:0] last_data = 8'h00;
  logic       last_pe = 1'b0;
  logic       last_fe = 1'b0;
  logic       last_brk = 1'b0;

  uart_receiver #(.SYNC_STAGES(2), .MID_SAMPLE(7)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .RXD(RXD), .enable(enable), .LCR(LCR),
    .rx_fifo_full(rx_fifo_full), .rx_data(rx_data), .rx_push(rx_push),
    .parity_error(parity_error), .framing_error(framing_error),
    .break_int(break_int), .overrun_error(overrun_error), .rx_busy(rx_busy),
    .state_dbg(state_dbg)
  );

  // Clock and 16x tick: one PCLK-wide enable every 4 cycles.
  always #5 PCLK = ~PCLK;

  initial begin
    forever begin
      repeat (3) @(negedge PCLK);
      enable = 1'b1;
      @(negedge PCLK);
      enable = 1'b0;
    end
  end

  // Capture completions away from the active edge.
  always @(negedge PCLK) begin
    if (rx_push) begin
      push_cnt  = push_cnt + 1;
      last_data = rx_data;
      last_pe   = parity_error;
      last_fe   = framing_error;
      last_brk  = break_int;
    end
    if (overrun_error) ovr_cnt = ovr_cnt + 1;
    if (rx_busy) busy_cnt = busy_cnt + 1;
  end

  // Watchdog.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  // Wait for the next enable tick, then step 1 ns past the edge.
  task automatic wait_en();
    @(posedge PCLK);
    while (!enable) @(posedge PCLK);
    #1;
  endtask

  task automatic send_bits(input logic b, input int n);
    RXD = b;
    repeat (n) wait_en();
  endtask

  task automatic send_frame(input int nb, input logic [7:0] d, input logic pen,
                            input logic pval, input logic stopv);
    wait_en();
    send_bits(1'b0, 16);
    for (int i = 0; i < nb; i++) send_bits(d[i], 16);
    if (pen) send_bits(pval, 16);
    send_bits(stopv, 16);
    send_bits(1'b1, 8);
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    repeat (3) @(negedge PCLK);
    n_checks++;
    if ({rx_push, parity_error, framing_error, break_int, overrun_error, rx_busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, required 000000",
               {rx_push, parity_error, framing_error, break_int, overrun_error, rx_busy});
    end
    n_checks++;
    if (rx_data !== 8'h00 || state_dbg !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_data_state: got data %h state %0d, required 00 / 0", rx_data, state_dbg);
    end
    PRESETn = 1'b1;
    send_bits(1'b1, 4);
  endtask

  task automatic test_8n1();
    int p0;
    LCR = 8'h03;
    p0 = push_cnt;
    send_frame(8, 8'hA5, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (push_cnt - p0 !== 1) begin
      n_fail++;
      $display("FAIL 8n1_push_count: got %0d, required 1", push_cnt - p0);
    end
    n_checks++;
    if (last_data !== 8'hA5 || {last_pe, last_fe, last_brk} !== 3'b000) begin
      n_fail++;
      $display("FAIL 8n1_data: got %h pe/fe/brk %b, required a5 000",
               last_data, {last_pe, last_fe, last_brk});
    end
  endtask

  task automatic test_parity();
    int p0;
    // 7-bit even, 0x35 has four ones so the correct bit is 0; send 1.
    LCR = 8'h0A;
    p0 = push_cnt;
    send_frame(7, 8'h35, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (push_cnt - p0 !== 1 || last_data !== 8'h35 || {last_pe, last_fe, last_brk} !== 3'b100) begin
      n_fail++;
      $display("FAIL parity_even_bad: got n=%0d %h %b, required n=1 35 100",
               push_cnt - p0, last_data, {last_pe, last_fe, last_brk});
    end
    // 8-bit odd, 0xA5 has four ones so the correct bit is 1.
    LCR = 8'h1B;
    p0 = push_cnt;
    send_frame(8, 8'hA5, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (push_cnt - p0 !== 1 || last_data !== 8'hA5 || {last_pe, last_fe, last_brk} !== 3'b000) begin
      n_fail++;
      $display("FAIL parity_odd_good: got n=%0d %h %b, required n=1 a5 000",
               push_cnt - p0, last_data, {last_pe, last_fe, last_brk});
    end
    // 6-bit, parity forced to 1; send 0.
    LCR = 8'h29;
    p0 = push_cnt;
    send_frame(6, 8'h2A, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (push_cnt - p0 !== 1 || last_data !== 8'h2A || {last_pe, last_fe, last_brk} !== 3'b100) begin
      n_fail++;
      $display("FAIL parity_stick1_bad: got n=%0d %h %b, required n=1 2a 100",
               push_cnt - p0, last_data, {last_pe, last_fe, last_brk});
    end
  endtask

  task automatic test_framing();
    int p0;
    LCR = 8'h00;
    p0 = push_cnt;
    send_frame(5, 8'h1F, 1'b0, 1'b0, 1'b0);
    send_bits(1'b1, 24);
    n_checks++;
    if (push_cnt - p0 !== 1 || last_data !== 8'h1F || {last_pe, last_fe, last_brk} !== 3'b010) begin
      n_fail++;
      $display("FAIL framing_5n1: got n=%0d %h %b, required n=1 1f 010",
               push_cnt - p0, last_data, {last_pe, last_fe, last_brk});
    end
    n_checks++;
    if (rx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL framing_idle_after: got busy %b, required 0", rx_busy);
    end
  endtask

  task automatic test_break();
    int p0;
    LCR = 8'h03;
    p0 = push_cnt;
    wait_en();
    send_bits(1'b0, 320);
    n_checks++;
    if (push_cnt - p0 !== 1 || last_data !== 8'h00 || {last_pe, last_fe, last_brk} !== 3'b011) begin
      n_fail++;
      $display("FAIL break_detect: got n=%0d %h %b, required n=1 00 011",
               push_cnt - p0, last_data, {last_pe, last_fe, last_brk});
    end
    n_checks++;
    if (rx_busy !== 1'b1 || state_dbg !== 3'd5) begin
      n_fail++;
      $display("FAIL break_wait: got busy %b state %0d, required 1 / 5", rx_busy, state_dbg);
    end
    send_bits(1'b1, 4);
    n_checks++;
    if (rx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL break_release: got busy %b, required 0", rx_busy);
    end
    p0 = push_cnt;
    send_frame(8, 8'h5A, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (push_cnt - p0 !== 1 || last_data !== 8'h5A || {last_pe, last_fe, last_brk} !== 3'b000) begin
      n_fail++;
      $display("FAIL break_next_frame: got n=%0d %h %b, required n=1 5a 000",
               push_cnt - p0, last_data, {last_pe, last_fe, last_brk});
    end
  endtask

  task automatic test_false_start();
    int p0;
    int b0;
    LCR = 8'h03;
    p0 = push_cnt;
    b0 = busy_cnt;
    wait_en();
    send_bits(1'b0, 4);
    send_bits(1'b1, 24);
    n_checks++;
    if (push_cnt - p0 !== 0 || busy_cnt == b0 || rx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL false_start: got pushes %0d busy_cycles %0d busy %b, required 0 >0 0",
               push_cnt - p0, busy_cnt - b0, rx_busy);
    end
    send_frame(8, 8'h3C, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (push_cnt - p0 !== 1 || last_data !== 8'h3C || {last_pe, last_fe, last_brk} !== 3'b000) begin
      n_fail++;
      $display("FAIL after_false_start: got n=%0d %h %b, required n=1 3c 000",
               push_cnt - p0, last_data, {last_pe, last_fe, last_brk});
    end
  endtask

  task automatic test_overrun();
    int p0;
    int o0;
    LCR = 8'h03;
    rx_fifo_full = 1'b1;
    p0 = push_cnt;
    o0 = ovr_cnt;
    send_frame(8, 8'h55, 1'b0, 1'b0, 1'b1);
    rx_fifo_full = 1'b0;
    n_checks++;
    if (push_cnt - p0 !== 0 || ovr_cnt - o0 !== 1) begin
      n_fail++;
      $display("FAIL overrun: got pushes %0d overrun_cycles %0d, required 0 / 1",
               push_cnt - p0, ovr_cnt - o0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int p0;
    LCR = 8'h03;
    p0 = push_cnt;
    wait_en();
    send_bits(1'b0, 16);
    send_bits(1'b1, 16);
    send_bits(1'b0, 8);
    n_checks++;
    if (rx_busy !== 1'b1 || state_dbg !== 3'd2) begin
      n_fail++;
      $display("FAIL mid_frame_busy: got busy %b state %0d, required 1 / 2", rx_busy, state_dbg);
    end
    #2 PRESETn = 1'b0;
    #1;
    n_checks++;
    if ({rx_push, parity_error, framing_error, break_int, overrun_error, rx_busy} !== 6'b0 ||
        state_dbg !== 3'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %b state %0d, required 000000 / 0",
               {rx_push, parity_error, framing_error, break_int, overrun_error, rx_busy}, state_dbg);
    end
    RXD = 1'b1;
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b1;
    send_bits(1'b1, 20);
    n_checks++;
    if (push_cnt - p0 !== 0) begin
      n_fail++;
      $display("FAIL reset_no_push: got pushes %0d, required 0", push_cnt - p0);
    end
    send_frame(8, 8'h81, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (push_cnt - p0 !== 1 || last_data !== 8'h81 || {last_pe, last_fe, last_brk} !== 3'b000) begin
      n_fail++;
      $display("FAIL after_reset_frame: got n=%0d %h %b, required n=1 81 000",
               push_cnt - p0, last_data, {last_pe, last_fe, last_brk});
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_framing();
    test_break();
    test_false_start();
    test_overrun();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
